down_counter_borrow: RTL and testbench



---
 rtl/down_counter_borrow.sv | 131 +++++++++++++
 tb/tb_down_counter_borrow.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/down_counter_borrow.sv
// down_counter_borrow
// ---------------------------------------------------------------------------
// Loadable WIDTH-bit decrementer. It is the subtract-one counterpart of the
// add-one incrementer and serves as a countdown timer or loop counter.
//
// Modes (WRAP parameter):
//   WRAP = 0  one-shot: counting stops at zero and done_o is raised.
//   WRAP = 1  wrap:     0 rolls over to 2^WIDTH-1 and stat_o pulses once.
//
// Ports:
//   clk         clock, rising-edge active
//   rst         asynchronous, active-high reset
//   load_i      synchronous load of load_val_i; this also starts a count
//   load_val_i  value to load (WIDTH bits)
//   en_i        decrement enable; one step per cycle in RUN
//   ack_i       clears done_o and returns the FSM to IDLE
//   count_o     current counter value (registered)
//   stat_o      borrow pulse on a 0 -> max wrap (WRAP = 1 only)
//   done_o      one-shot expiry flag (WRAP = 0 only); held until ack or load
//   busy_o      high while the FSM is in RUN (registered)
//
// Command priority is load > ack > en in every state.
// ---------------------------------------------------------------------------
module down_counter_borrow #(
  parameter int WIDTH = 2,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] count_o,
  output logic             stat_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam bit WrapMode = (WRAP != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             stat_q,  stat_d;
  logic             done_q,  done_d;
  logic             busy_q,  busy_d;

  logic             countIsZero;
  logic             countIsOne;
  logic             loadIsZero;

  assign countIsZero = (count_q == '0);
  assign countIsOne  = (count_q == WIDTH'(1));
  assign loadIsZero  = (load_val_i == '0);

  // Next-state logic. stat is a single-cycle pulse, so it defaults low and is
  // raised only on the edge that performs a wrap. done is a level signal:
  // only an expiry, an ack or a load can change it.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    stat_d  = 1'b0;
    done_d  = done_q;

    if (load_i) begin
      count_d = load_val_i;
      // In one-shot mode, loading zero means the count has already expired.
      if (!WrapMode && loadIsZero) begin
        state_d = EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
        done_d  = 1'b0;
      end
    end else if (ack_i) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else if (en_i && (state_q == RUN)) begin
      if (countIsZero) begin
        if (WrapMode) begin
          // Borrow: the modulo subtract wraps to all ones.
          count_d = count_q - WIDTH'(1);
          stat_d  = 1'b1;
        end else begin
          state_d = EXPIRED;
          done_d  = 1'b1;
        end
      end else begin
        count_d = count_q - WIDTH'(1);
        // Done is raised on the edge where zero is reached, so it lines up
        // with count reading 0.
        if (!WrapMode && countIsOne) begin
          state_d = EXPIRED;
          done_d  = 1'b1;
        end
      end
    end

    busy_d = (state_d == RUN);
  end

  // State and output registers. Reset clears everything at once, without
  // waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      stat_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      stat_q  <= stat_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign count_o = count_q;
  assign stat_o  = stat_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_down_counter_borrow.sv
// Testbench for down_counter_borrow. Two instances share one clock and reset:
// dut0 runs in one-shot mode (WRAP=0) and dut1 runs in wrap mode (WRAP=1).
// Both use WIDTH=2.
// Every directed step pushes its expected {count, stat, done, busy} into a
// scoreboard queue. After the next rising edge, that entry is popped and
// compared against the instance it targets.
module tb_down_counter_borrow;

   logic clk = 1'b0;
   logic rst;

   logic       load0, en0, ack0;
   logic [1:0] val0;
   logic [1:0] count0;
   logic       stat0, done0, busy0;

   logic       load1, en1, ack1;
   logic [1:0] val1;
   logic [1:0] count1;
   logic       stat1, done1, busy1;

   typedef struct {
      bit         sel;
      logic [4:0] expVec;
      string      tag;
   } exp_t;

   exp_t scoreboard[$];
   int   checks = 0;
   int   errors = 0;

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   down_counter_borrow #(.WIDTH(2), .WRAP(0)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load0),
      .load_val_i (val0),
      .en_i       (en0),
      .ack_i      (ack0),
      .count_o    (count0),
      .stat_o     (stat0),
      .done_o     (done0),
      .busy_o     (busy0)
   );

   down_counter_borrow #(.WIDTH(2), .WRAP(1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load1),
      .load_val_i (val1),
      .en_i       (en1),
      .ack_i      (ack1),
      .count_o    (count1),
      .stat_o     (stat1),
      .done_o     (done1),
      .busy_o     (busy1)
   );

   // Packs the observed outputs of one instance as {count, stat, done, busy}.
   function automatic logic [4:0] observed(bit sel);
      if (sel) return {count1, stat1, done1, busy1};
      return {count0, stat0, done0, busy0};
   endfunction

   // Compares one instance against an expected vector and counts the check.
   task automatic compareNow(string tag, bit sel, logic [4:0] expVec);
      logic [4:0] obsVec;
      obsVec = observed(sel);
      checks++;
      assert (obsVec === expVec) else begin
         errors++;
         $error("[TB] FAIL %s dut%0d observed {count,stat,done,busy}=%b required=%b",
                tag, sel, obsVec, expVec);
      end
   endtask

   // Pops the oldest scoreboard entry and compares it against the DUT.
   task automatic checkOutput();
      exp_t e;
      if (scoreboard.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_empty observed=0 entries required>=1");
      end else begin
         e = scoreboard.pop_front();
         compareNow(e.tag, e.sel, e.expVec);
      end
   endtask

   // Drives one cycle of stimulus on the selected instance and idles the
   // other. It records the expected result, then checks it just after the
   // rising edge.
   task automatic applyStimulus(bit sel, logic ld, logic [1:0] val, logic en,
                                logic ack, logic [1:0] expCount, logic expStat,
                                logic expDone, logic expBusy, string tag);
      exp_t e;
      @(negedge clk);
      load0 = sel ? 1'b0 : ld;
      val0  = sel ? 2'd0 : val;
      en0   = sel ? 1'b0 : en;
      ack0  = sel ? 1'b0 : ack;
      load1 = sel ? ld   : 1'b0;
      val1  = sel ? val  : 2'd0;
      en1   = sel ? en   : 1'b0;
      ack1  = sel ? ack  : 1'b0;
      e.sel    = sel;
      e.expVec = {expCount, expStat, expDone, expBusy};
      e.tag    = tag;
      scoreboard.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      rst   = 1'b1;
      load0 = 1'b0; val0 = 2'd0; en0 = 1'b0; ack0 = 1'b0;
      load1 = 1'b0; val1 = 2'd0; en1 = 1'b0; ack1 = 1'b0;

      // Reset state of both instances.
      #12;
      compareNow("reset0", 1'b0, 5'b00_0_0_0);
      compareNow("reset1", 1'b1, 5'b00_0_0_0);
      @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of a count.
      applyStimulus(0, 1, 2'd3, 0, 0, 2'd3, 0, 0, 1, "midrst_load3");
      applyStimulus(0, 0, 2'd0, 1, 0, 2'd2, 0, 0, 1, "midrst_dec");
      #2 rst = 1'b1;
      #1 compareNow("midrst_async", 1'b0, 5'b00_0_0_0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 0, 2'd0, 1, 0, 2'd0, 0, 0, 0, "idle_en_ign1");
      applyStimulus(0, 0, 2'd0, 1, 0, 2'd0, 0, 0, 0, "idle_en_ign2");

      // One-shot countdown. Load beats the en that arrives with it.
      applyStimulus(0, 1, 2'd3, 1, 0, 2'd3, 0, 0, 1, "oneshot_load3");
      applyStimulus(0, 0, 2'd0, 1, 0, 2'd2, 0, 0, 1, "oneshot_2");
      applyStimulus(0, 0, 2'd0, 1, 0, 2'd1, 0, 0, 1, "oneshot_1");
      applyStimulus(0, 0, 2'd0, 1, 0, 2'd0, 0, 1, 0, "oneshot_0_done");
      applyStimulus(0, 0, 2'd0, 1, 0, 2'd0, 0, 1, 0, "oneshot_hold0");
      applyStimulus(0, 0, 2'd0, 1, 1, 2'd0, 0, 0, 0, "oneshot_ack");
      applyStimulus(0, 0, 2'd0, 1, 0, 2'd0, 0, 0, 0, "oneshot_idle");

      // Wrap with borrow: stat pulses on each 0 -> 3 step, four cycles apart.
      applyStimulus(1, 1, 2'd1, 0, 0, 2'd1, 0, 0, 1, "wrap_load1");
      applyStimulus(1, 0, 2'd0, 1, 0, 2'd0, 0, 0, 1, "wrap_0");
      applyStimulus(1, 0, 2'd0, 1, 0, 2'd3, 1, 0, 1, "wrap_borrow1");
      applyStimulus(1, 0, 2'd0, 1, 0, 2'd2, 0, 0, 1, "wrap_2");
      applyStimulus(1, 0, 2'd0, 1, 0, 2'd1, 0, 0, 1, "wrap_1");
      applyStimulus(1, 0, 2'd0, 1, 0, 2'd0, 0, 0, 1, "wrap_0b");
      applyStimulus(1, 0, 2'd0, 1, 0, 2'd3, 1, 0, 1, "wrap_borrow2");
      applyStimulus(1, 0, 2'd0, 0, 0, 2'd3, 0, 0, 1, "wrap_en0_hold");

      // Load and en in the same cycle: load wins and nothing is decremented.
      applyStimulus(0, 1, 2'd3, 0, 0, 2'd3, 0, 0, 1, "coll_load3");
      applyStimulus(0, 0, 2'd0, 1, 0, 2'd2, 0, 0, 1, "coll_2");
      applyStimulus(0, 1, 2'd1, 1, 0, 2'd1, 0, 0, 1, "coll_load_wins");
      applyStimulus(0, 0, 2'd0, 1, 0, 2'd0, 0, 1, 0, "coll_dec_0");

      // Pause: count holds while en is low.
      applyStimulus(1, 1, 2'd3, 0, 0, 2'd3, 0, 0, 1, "pause_load3");
      applyStimulus(1, 0, 2'd0, 1, 0, 2'd2, 0, 0, 1, "pause_en1");
      applyStimulus(1, 0, 2'd0, 0, 0, 2'd2, 0, 0, 1, "pause_en0a");
      applyStimulus(1, 0, 2'd0, 0, 0, 2'd2, 0, 0, 1, "pause_en0b");
      applyStimulus(1, 0, 2'd0, 1, 0, 2'd1, 0, 0, 1, "pause_en1b");

      // Loading zero in one-shot mode goes straight to EXPIRED.
      applyStimulus(0, 0, 2'd0, 0, 1, 2'd0, 0, 0, 0, "zero_ack_idle");
      applyStimulus(0, 1, 2'd0, 0, 0, 2'd0, 0, 1, 0, "zero_load_exp");
      applyStimulus(0, 0, 2'd0, 1, 0, 2'd0, 0, 1, 0, "zero_exp_en_ign");
      applyStimulus(0, 1, 2'd2, 0, 1, 2'd2, 0, 0, 1, "zero_reload2");

      // Loading zero in wrap mode starts RUN, and the first step borrows.
      applyStimulus(1, 1, 2'd0, 0, 0, 2'd0, 0, 0, 1, "wrapz_load0");
      applyStimulus(1, 0, 2'd0, 1, 0, 2'd3, 1, 0, 1, "wrapz_borrow");

      if (scoreboard.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_leftover observed=%0d entries required=0",
                  scoreboard.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guards against a hang if the stimulus ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL timeout observed=running required=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
